// File: rtl/rs_wakeup_queue_pkg.sv
// Shared types for the reservation station: CDB broadcast format and per-entry operand/entry state.
package rs_wakeup_queue_pkg;

  localparam int unsigned TAG_W = 4;
  localparam int unsigned XLEN  = 32;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
    logic             br_en;
    logic [XLEN-1:0]  br_target;
  } cdb_t;

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } rs_operand_t;

  // Payload lives in a separate array so this struct stays unparameterized.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] rd_tag;
    rs_operand_t      rs1;
    rs_operand_t      rs2;
  } rs_entry_t;

endpackage

// File: rtl/rs_wakeup_queue_operand_wakeup.sv
// Combinational operand wakeup: a pending operand captures the value of a matching CDB, lowest index wins.
module rs_operand_wakeup
  import rs_wakeup_queue_pkg::*;
#(
  parameter int unsigned NUM_CDB = 4
) (
  input  rs_operand_t op_in,
  input  cdb_t        cdb_i [NUM_CDB],
  output rs_operand_t op_out
);

  logic br_unused;

  always_comb begin
    op_out = op_in;
    if (!op_in.rdy) begin
      // Walk from highest to lowest so the lowest-index match is applied last.
      for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
        if (cdb_i[k].valid && (cdb_i[k].tag == op_in.tag)) begin
          op_out.rdy = 1'b1;
          op_out.val = cdb_i[k].value;
        end
      end
    end
  end

  // Branch-resolution fields of the CDB are not relevant to operand capture.
  always_comb begin
    br_unused = 1'b0;
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      br_unused = br_unused ^ cdb_i[k].br_en ^ (^cdb_i[k].br_target);
    end
  end

endmodule

// File: rtl/rs_wakeup_queue.sv
// Reservation station: holds dispatched instructions, snoops CDBs for operands, issues lowest ready entry.
module rs_wakeup_queue
  import rs_wakeup_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_CDB   = 4,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  cdb_t                         cdb_i [NUM_CDB],
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [TAG_W-1:0]             disp_rd_tag,
  input  logic                         disp_rs1_rdy,
  input  logic                         disp_rs2_rdy,
  input  logic [TAG_W-1:0]             disp_rs1_tag,
  input  logic [TAG_W-1:0]             disp_rs2_tag,
  input  logic [XLEN-1:0]              disp_rs1_val,
  input  logic [XLEN-1:0]              disp_rs2_val,
  input  logic [PAYLOAD_W-1:0]         disp_payload,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [TAG_W-1:0]             iss_rd_tag,
  output logic [XLEN-1:0]              iss_rs1_val,
  output logic [XLEN-1:0]              iss_rs2_val,
  output logic [PAYLOAD_W-1:0]         iss_payload,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  rs_entry_t            ents     [DEPTH];
  rs_entry_t            ents_nxt [DEPTH];
  logic [PAYLOAD_W-1:0] pay      [DEPTH];
  logic [PAYLOAD_W-1:0] pay_nxt  [DEPTH];
  rs_operand_t          wake1    [DEPTH];
  rs_operand_t          wake2    [DEPTH];
  rs_operand_t          byp_in1, byp_in2, byp1, byp2;

  logic             free_found, sel_found;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             disp_accept, iss_fire;
  logic [OCC_W-1:0] occ_nxt;

  // Per-entry wakeup against all CDBs.
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_wake
    rs_operand_wakeup #(.NUM_CDB(NUM_CDB)) u_wk_rs1 (
      .op_in  (ents[g].rs1),
      .cdb_i  (cdb_i),
      .op_out (wake1[g])
    );
    rs_operand_wakeup #(.NUM_CDB(NUM_CDB)) u_wk_rs2 (
      .op_in  (ents[g].rs2),
      .cdb_i  (cdb_i),
      .op_out (wake2[g])
    );
  end

  // Dispatch bypass: catch a broadcast that lands in the same cycle as the dispatch.
  always_comb begin
    byp_in1 = '{rdy: disp_rs1_rdy, tag: disp_rs1_tag, val: disp_rs1_val};
    byp_in2 = '{rdy: disp_rs2_rdy, tag: disp_rs2_tag, val: disp_rs2_val};
  end

  rs_operand_wakeup #(.NUM_CDB(NUM_CDB)) u_byp_rs1 (
    .op_in  (byp_in1),
    .cdb_i  (cdb_i),
    .op_out (byp1)
  );
  rs_operand_wakeup #(.NUM_CDB(NUM_CDB)) u_byp_rs2 (
    .op_in  (byp_in2),
    .cdb_i  (cdb_i),
    .op_out (byp2)
  );

  // Lowest-index free slot and lowest-index ready slot, from registered state only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!ents[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ents[i].valid && ents[i].rs1.rdy && ents[i].rs2.rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready  = free_found;
  assign iss_valid   = sel_found;
  assign disp_accept = disp_valid && free_found && !flush;
  assign iss_fire    = sel_found && iss_ready;

  // Issue outputs are zeroed when nothing qualifies.
  always_comb begin
    iss_rd_tag  = '0;
    iss_rs1_val = '0;
    iss_rs2_val = '0;
    iss_payload = '0;
    if (sel_found) begin
      iss_rd_tag  = ents[sel_idx].rd_tag;
      iss_rs1_val = ents[sel_idx].rs1.val;
      iss_rs2_val = ents[sel_idx].rs2.val;
      iss_payload = pay[sel_idx];
    end
  end

  // Next-state: wakeup, issue invalidation, allocation, then flush overrides everything.
  always_comb begin
    ents_nxt = ents;
    pay_nxt  = pay;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (ents[i].valid) begin
        ents_nxt[i].rs1 = wake1[i];
        ents_nxt[i].rs2 = wake2[i];
      end
    end
    if (iss_fire) begin
      ents_nxt[sel_idx].valid = 1'b0;
    end
    if (disp_accept) begin
      ents_nxt[free_idx] = '{valid: 1'b1, rd_tag: disp_rd_tag, rs1: byp1, rs2: byp2};
      pay_nxt[free_idx]  = disp_payload;
    end
    if (flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ents_nxt[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    occ_nxt = occupancy + OCC_W'(disp_accept) - OCC_W'(iss_fire);
    if (flush) begin
      occ_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ents[i] <= '0;
        pay[i]  <= '0;
      end
      occupancy <= '0;
    end else begin
      ents      <= ents_nxt;
      pay       <= pay_nxt;
      occupancy <= occ_nxt;
    end
  end

endmodule

// File: tb/tb_rs_wakeup_queue.sv
// Directed self-checking bench for rs_wakeup_queue: dispatch, wakeup, bypass, full, priority, flush, reset.
module tb_rs_wakeup_queue;
  import rs_wakeup_queue_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned NUM_CDB   = 4;
  localparam int unsigned PAYLOAD_W = 64;
  localparam int unsigned OCC_W     = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  cdb_t                 cdb [NUM_CDB];
  logic                 disp_valid;
  logic                 disp_ready;
  logic [TAG_W-1:0]     disp_rd_tag;
  logic                 disp_rs1_rdy, disp_rs2_rdy;
  logic [TAG_W-1:0]     disp_rs1_tag, disp_rs2_tag;
  logic [XLEN-1:0]      disp_rs1_val, disp_rs2_val;
  logic [PAYLOAD_W-1:0] disp_payload;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [TAG_W-1:0]     iss_rd_tag;
  logic [XLEN-1:0]      iss_rs1_val, iss_rs2_val;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [OCC_W-1:0]     occupancy;

  int total = 0;
  int bad   = 0;

  rs_wakeup_queue #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .cdb_i        (cdb),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_rd_tag  (disp_rd_tag),
    .disp_rs1_rdy (disp_rs1_rdy),
    .disp_rs2_rdy (disp_rs2_rdy),
    .disp_rs1_tag (disp_rs1_tag),
    .disp_rs2_tag (disp_rs2_tag),
    .disp_rs1_val (disp_rs1_val),
    .disp_rs2_val (disp_rs2_val),
    .disp_payload (disp_payload),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_rd_tag   (iss_rd_tag),
    .iss_rs1_val  (iss_rs1_val),
    .iss_rs2_val  (iss_rs2_val),
    .iss_payload  (iss_payload),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb_clear();
    for (int k = 0; k < int'(NUM_CDB); k++) cdb[k] = '0;
  endtask

  task automatic cdb_send(input int k, input logic [3:0] tag, input logic [31:0] val);
    cdb[k] = '{valid: 1'b1, tag: tag, value: val, br_en: 1'b1, br_target: 32'hFFFF_0000};
  endtask

  task automatic disp(input logic [3:0] rd, input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [3:0] t2, input logic [31:0] v2);
    disp_valid   = 1'b1;
    disp_rd_tag  = rd;
    disp_rs1_rdy = r1;
    disp_rs1_tag = t1;
    disp_rs1_val = v1;
    disp_rs2_rdy = r2;
    disp_rs2_tag = t2;
    disp_rs2_val = v2;
    disp_payload = {32'hC0DE_0000, 28'h0, rd};
  endtask

  task automatic test_reset();
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_iss_valid got=%0b exp=0", iss_valid); end
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL reset_disp_ready got=%0b exp=1", disp_ready); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    total++; if (iss_rd_tag !== 4'd0 || iss_rs1_val !== 32'd0 || iss_payload !== 64'd0) begin
      bad++; $display("FAIL reset_iss_zero tag=%0h rs1=%0h pay=%0h exp=0", iss_rd_tag, iss_rs1_val, iss_payload);
    end
  endtask

  task automatic test_basic_issue();
    disp(4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7);
    tick();
    disp_valid = 1'b0;
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL basic_iss_valid got=%0b exp=1", iss_valid); end
    total++; if (iss_rd_tag !== 4'd3) begin bad++; $display("FAIL basic_rd_tag got=%0d exp=3", iss_rd_tag); end
    total++; if (iss_rs1_val !== 32'd5 || iss_rs2_val !== 32'd7) begin
      bad++; $display("FAIL basic_vals got=%0d/%0d exp=5/7", iss_rs1_val, iss_rs2_val);
    end
    total++; if (iss_payload !== 64'hC0DE_0000_0000_0003) begin
      bad++; $display("FAIL basic_payload got=%0h exp=c0de000000000003", iss_payload);
    end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL basic_occ got=%0d exp=1", occupancy); end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL basic_after_iss_valid got=%0b exp=0", iss_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL basic_after_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_cdb_wakeup();
    disp(4'd4, 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'd1);
    tick();
    disp_valid = 1'b0;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wake_pending_t1 got=%0b exp=0", iss_valid); end
    tick();
    cdb_send(1, 4'd9, 32'hDEAD_BEEF);
    #1;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL wake_no_forward got=%0b exp=0", iss_valid); end
    tick();
    cdb_clear();
    total++; if (iss_valid !== 1'b1 || iss_rd_tag !== 4'd4) begin
      bad++; $display("FAIL wake_iss got valid=%0b tag=%0d exp valid=1 tag=4", iss_valid, iss_rd_tag);
    end
    total++; if (iss_rs1_val !== 32'hDEAD_BEEF || iss_rs2_val !== 32'd1) begin
      bad++; $display("FAIL wake_vals got=%0h/%0h exp=deadbeef/1", iss_rs1_val, iss_rs2_val);
    end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL wake_drain_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_dispatch_bypass();
    disp(4'd5, 1'b1, 4'd0, 32'h22, 1'b0, 4'd2, 32'h0);
    cdb_send(3, 4'd2, 32'h11);
    tick();
    disp_valid = 1'b0;
    cdb_clear();
    total++; if (iss_valid !== 1'b1 || iss_rd_tag !== 4'd5) begin
      bad++; $display("FAIL bypass_iss got valid=%0b tag=%0d exp valid=1 tag=5", iss_valid, iss_rd_tag);
    end
    total++; if (iss_rs2_val !== 32'h11 || iss_rs1_val !== 32'h22) begin
      bad++; $display("FAIL bypass_vals got=%0h/%0h exp=22/11", iss_rs1_val, iss_rs2_val);
    end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < int'(DEPTH); i++) begin
      disp(4'(i), 1'b0, 4'(10 + i), 32'd0, 1'b1, 4'd0, 32'd100);
      tick();
    end
    disp_valid = 1'b0;
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_disp_ready got=%0b exp=0", disp_ready); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ got=%0d exp=4", occupancy); end
    disp(4'd7, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
    tick();
    disp_valid = 1'b0;
    total++; if (occupancy !== 3'd4 || iss_valid !== 1'b0) begin
      bad++; $display("FAIL full_fifth_dropped got occ=%0d valid=%0b exp occ=4 valid=0", occupancy, iss_valid);
    end
    cdb_send(0, 4'd12, 32'h1234);
    tick();
    cdb_clear();
    total++; if (iss_valid !== 1'b1 || iss_rd_tag !== 4'd2 || iss_rs1_val !== 32'h1234) begin
      bad++; $display("FAIL full_wake_e2 got valid=%0b tag=%0d rs1=%0h exp 1/2/1234", iss_valid, iss_rd_tag, iss_rs1_val);
    end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    total++; if (disp_ready !== 1'b1 || occupancy !== 3'd3 || iss_valid !== 1'b0) begin
      bad++; $display("FAIL full_freed got rdy=%0b occ=%0d valid=%0b exp 1/3/0", disp_ready, occupancy, iss_valid);
    end
  endtask

  task automatic test_cdb_priority();
    disp(4'd6, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd0);
    tick();
    disp_valid = 1'b0;
    cdb_send(0, 4'd6, 32'hA);
    cdb_send(2, 4'd6, 32'hB);
    tick();
    cdb_clear();
    total++; if (iss_valid !== 1'b1 || iss_rd_tag !== 4'd6) begin
      bad++; $display("FAIL prio_iss got valid=%0b tag=%0d exp valid=1 tag=6", iss_valid, iss_rd_tag);
    end
    total++; if (iss_rs1_val !== 32'hA) begin bad++; $display("FAIL prio_val got=%0h exp=a", iss_rs1_val); end
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
  endtask

  task automatic test_flush();
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=3", occupancy); end
    flush = 1'b1;
    disp(4'd9, 1'b1, 4'd0, 32'd9, 1'b1, 4'd0, 32'd9);
    tick();
    flush = 1'b0;
    disp_valid = 1'b0;
    total++; if (occupancy !== 3'd0 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      bad++; $display("FAIL flush_clear got occ=%0d valid=%0b rdy=%0b exp 0/0/1", occupancy, iss_valid, disp_ready);
    end
    cdb_send(0, 4'd10, 32'h5);
    cdb_send(1, 4'd11, 32'h6);
    tick();
    cdb_clear();
    total++; if (iss_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL flush_stale got valid=%0b occ=%0d exp 0/0", iss_valid, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    disp(4'd1, 1'b1, 4'd0, 32'd11, 1'b1, 4'd0, 32'd12);
    tick();
    disp(4'd2, 1'b1, 4'd0, 32'd21, 1'b1, 4'd0, 32'd22);
    iss_ready = 1'b1;
    total++; if (iss_rd_tag !== 4'd1) begin bad++; $display("FAIL b2b_first_tag got=%0d exp=1", iss_rd_tag); end
    tick();
    disp_valid = 1'b0;
    iss_ready  = 1'b0;
    total++; if (occupancy !== 3'd1 || iss_valid !== 1'b1 || iss_rd_tag !== 4'd2 || iss_rs2_val !== 32'd22) begin
      bad++; $display("FAIL b2b got occ=%0d valid=%0b tag=%0d rs2=%0d exp 1/1/2/22", occupancy, iss_valid, iss_rd_tag, iss_rs2_val);
    end
  endtask

  task automatic test_async_reset();
    disp(4'd8, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
    tick();
    disp_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (iss_valid !== 1'b0 || occupancy !== 3'd0 || disp_ready !== 1'b1 || iss_rd_tag !== 4'd0) begin
      bad++; $display("FAIL async_reset got valid=%0b occ=%0d rdy=%0b tag=%0d exp 0/0/1/0", iss_valid, occupancy, disp_ready, iss_rd_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (iss_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL async_reset_hold got valid=%0b occ=%0d exp 0/0", iss_valid, occupancy);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    disp_valid   = 1'b0;
    disp_rd_tag  = '0;
    disp_rs1_rdy = 1'b0;
    disp_rs2_rdy = 1'b0;
    disp_rs1_tag = '0;
    disp_rs2_tag = '0;
    disp_rs1_val = '0;
    disp_rs2_val = '0;
    disp_payload = '0;
    iss_ready    = 1'b0;
    cdb_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_basic_issue();
    test_cdb_wakeup();
    test_dispatch_bypass();
    test_full();
    test_cdb_priority();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
